// File: rtl/rx_ipv4.sv
// IPv4 receive stage: parses/validates the header, filters on ip_addr, forwards payload.
// Optional header checksum verification is built when RX_IPV4_CHECKSUM_EN is defined.
//
// state   | meaning
// IDLE    | waiting for header byte 0
// HEADER  | capturing fixed header bytes 1..19
// OPTIONS | skipping (IHL-5)*4 option bytes
// PAYLOAD | forwarding payload bytes until total_length is reached
// DROP    | discarding bytes (padding, rejected datagram) until valid falls
module rx_ipv4 #(
    parameter int         OCT    = 8,
    parameter logic [3:0] IP_VER = 4'h4
) (
    input  logic           RX_CLK,
    input  logic           rst,
    input  logic [31:0]    ip_addr,
    input  logic           rx_payload_ipv4,
    input  logic [OCT-1:0] rx_payload,
    output logic [31:0]    rx_ip_src,
    output logic [7:0]     rx_ip_proto,
    output logic [15:0]    rx_ip_len,
    output logic           rx_ipv4_valid,
    output logic [OCT-1:0] rx_ipv4_data,
    output logic           rx_ipv4_last,
    output logic           rx_ipv4_err
);

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_OPTIONS, S_PAYLOAD, S_DROP} state_t;

    state_t      state, state_nxt;
    logic [4:0]  hdr_cnt;
    logic [5:0]  opt_cnt;
    logic [15:0] pay_cnt;
    logic [7:0]  ver_ihl;
    logic [15:0] tot_len;
    logic        mf;
    logic [12:0] frag_off;
    logic [7:0]  proto_r;
    logic [31:0] src_r;
    logic [31:0] dst_r;

    logic [3:0]  ihl;
    logic [5:0]  ihl4;
    logic [15:0] pay_len;
    logic [15:0] pay_inc;
    logic [31:0] dst_full;
    logic        csum_ok;
    logic        hdr_ok;

    logic        check, load, fwd, last_nxt, err_nxt;

    assign ihl     = ver_ihl[3:0];
    assign ihl4    = {ihl, 2'b00};
    assign pay_len = tot_len - {10'd0, ihl4};
    assign pay_inc = pay_cnt + 16'd1;
    // Without options the check happens on byte 19, which is still on the input.
    assign dst_full = (state == S_HEADER) ? {dst_r[23:0], rx_payload} : dst_r;

`ifdef RX_IPV4_CHECKSUM_EN
    logic [15:0] cs_acc;
    logic [7:0]  cs_hi;
    logic        cs_odd;

    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    // The check byte is always the odd half of the final header word.
    assign csum_ok = (ones_add(cs_acc, {cs_hi, rx_payload}) == 16'hFFFF);

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            cs_acc <= '0;
            cs_hi  <= '0;
            cs_odd <= 1'b0;
        end else if (state == S_IDLE && rx_payload_ipv4) begin
            cs_acc <= '0;
            cs_hi  <= rx_payload;
            cs_odd <= 1'b1;
        end else if ((state == S_HEADER || state == S_OPTIONS) && rx_payload_ipv4) begin
            if (cs_odd)
                cs_acc <= ones_add(cs_acc, {cs_hi, rx_payload});
            else
                cs_hi <= rx_payload;
            cs_odd <= ~cs_odd;
        end
    end
`else
    assign csum_ok = 1'b1;
`endif

    assign hdr_ok = (ver_ihl[7:4] == IP_VER) && (ihl >= 4'd5) &&
                    (tot_len >= {10'd0, ihl4}) && !mf && (frag_off == 13'd0) && csum_ok;

    always_ff @(posedge RX_CLK) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        check     = 1'b0;
        load      = 1'b0;
        fwd       = 1'b0;
        last_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_payload_ipv4)
                    state_nxt = S_HEADER;
            end
            S_HEADER: begin
                if (!rx_payload_ipv4) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (hdr_cnt == 5'd19) begin
                    if (ihl > 4'd5)
                        state_nxt = S_OPTIONS;
                    else
                        check = 1'b1;
                end
            end
            S_OPTIONS: begin
                if (!rx_payload_ipv4) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (opt_cnt == 6'd0) begin
                    check = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (!rx_payload_ipv4) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    fwd = 1'b1;
                    if (pay_inc == rx_ip_len) begin
                        last_nxt  = 1'b1;
                        state_nxt = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (!rx_payload_ipv4)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (check) begin
            state_nxt = S_DROP;
            if (!hdr_ok) begin
                err_nxt = 1'b1;
            end else if (dst_full == ip_addr && pay_len != 16'd0) begin
                load      = 1'b1;
                state_nxt = S_PAYLOAD;
            end
        end
    end

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            hdr_cnt       <= '0;
            opt_cnt       <= '0;
            pay_cnt       <= '0;
            ver_ihl       <= '0;
            tot_len       <= '0;
            mf            <= 1'b0;
            frag_off      <= '0;
            proto_r       <= '0;
            src_r         <= '0;
            dst_r         <= '0;
            rx_ip_src     <= '0;
            rx_ip_proto   <= '0;
            rx_ip_len     <= '0;
            rx_ipv4_valid <= 1'b0;
            rx_ipv4_data  <= '0;
            rx_ipv4_last  <= 1'b0;
            rx_ipv4_err   <= 1'b0;
        end else begin
            rx_ipv4_valid <= fwd;
            rx_ipv4_last  <= last_nxt;
            rx_ipv4_err   <= err_nxt;

            if (state == S_IDLE && rx_payload_ipv4) begin
                ver_ihl <= rx_payload;
                hdr_cnt <= 5'd1;
            end

            if (state == S_HEADER && rx_payload_ipv4) begin
                hdr_cnt <= hdr_cnt + 5'd1;
                case (hdr_cnt)
                    5'd2:  tot_len[15:8]  <= rx_payload;
                    5'd3:  tot_len[7:0]   <= rx_payload;
                    5'd6: begin
                        mf             <= rx_payload[5];
                        frag_off[12:8] <= rx_payload[4:0];
                    end
                    5'd7:  frag_off[7:0]  <= rx_payload;
                    5'd9:  proto_r        <= rx_payload;
                    5'd12, 5'd13, 5'd14, 5'd15: src_r <= {src_r[23:0], rx_payload};
                    5'd16, 5'd17, 5'd18, 5'd19: dst_r <= {dst_r[23:0], rx_payload};
                    default: ;
                endcase
                if (hdr_cnt == 5'd19)
                    opt_cnt <= {ihl - 4'd5, 2'b00} - 6'd1;
            end

            if (state == S_OPTIONS && rx_payload_ipv4)
                opt_cnt <= opt_cnt - 6'd1;

            if (load) begin
                rx_ip_src   <= src_r;
                rx_ip_proto <= proto_r;
                rx_ip_len   <= pay_len;
                pay_cnt     <= '0;
            end

            if (fwd) begin
                rx_ipv4_data <= rx_payload;
                pay_cnt      <= pay_inc;
            end
        end
    end

endmodule

// File: tb/tb_rx_ipv4.sv
// Self-checking bench for rx_ipv4: table of datagrams plus reset/truncation sequences,
// payload bytes checked through an expected-byte queue.
module tb_rx_ipv4;

    localparam logic [31:0] LOC = 32'hC0A8010A;
    localparam logic [31:0] SRC = 32'hC0A80101;
`ifdef RX_IPV4_CHECKSUM_EN
    localparam bit CS_ON = 1'b1;
`else
    localparam bit CS_ON = 1'b0;
`endif

    logic        RX_CLK = 1'b0;
    logic        rst;
    logic [31:0] ip_addr;
    logic        rx_payload_ipv4;
    logic [7:0]  rx_payload;
    logic [31:0] rx_ip_src;
    logic [7:0]  rx_ip_proto;
    logic [15:0] rx_ip_len;
    logic        rx_ipv4_valid;
    logic [7:0]  rx_ipv4_data;
    logic        rx_ipv4_last;
    logic        rx_ipv4_err;

    rx_ipv4 dut (
        .RX_CLK          (RX_CLK),
        .rst             (rst),
        .ip_addr         (ip_addr),
        .rx_payload_ipv4 (rx_payload_ipv4),
        .rx_payload      (rx_payload),
        .rx_ip_src       (rx_ip_src),
        .rx_ip_proto     (rx_ip_proto),
        .rx_ip_len       (rx_ip_len),
        .rx_ipv4_valid   (rx_ipv4_valid),
        .rx_ipv4_data    (rx_ipv4_data),
        .rx_ipv4_last    (rx_ipv4_last),
        .rx_ipv4_err     (rx_ipv4_err)
    );

    always #5 RX_CLK = ~RX_CLK;

    typedef struct {
        logic [7:0]  ver_ihl;
        logic [15:0] tot;
        logic [15:0] frag;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [31:0] dst;
        int          hdr_bytes;   // 0 = whole header
        int          n_pay;
        int          pay_sent;
        int          n_pad;
        int          gap;
        bit          bad_cs;
        bit          exp_err;
        bit          exp_acc;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          err_seen = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  mon_e;
    logic [31:0] m_src = '0;
    logic [7:0]  m_proto = '0;
    logic [15:0] m_len = '0;
    logic [7:0]  hb[64];
    int          nh;
    vec_t        vt[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge RX_CLK) begin
        #1;
        if (rx_ipv4_err)
            err_seen++;
        if (rx_ipv4_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got data %h last %b, expected no valid", rx_ipv4_data, rx_ipv4_last);
            end else begin
                mon_e = exp_q.pop_front();
                chk("payload{last,data}", {23'd0, rx_ipv4_last, rx_ipv4_data}, {23'd0, mon_e});
            end
        end else if (rx_ipv4_last) begin
            checks++;
            failures++;
            $display("FAIL last_without_valid: got last 1, expected 0");
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(logic [7:0] vi, logic [15:0] tot, logic [15:0] frag,
                                logic [7:0] proto, logic [31:0] src, logic [31:0] dst,
                                int hdr_bytes, int n_pay, int pay_sent, int n_pad, int gap,
                                bit bad, bit err, bit acc);
        vec_t v;
        v.ver_ihl = vi;  v.tot = tot;  v.frag = frag;  v.proto = proto;
        v.src = src;  v.dst = dst;  v.hdr_bytes = hdr_bytes;  v.n_pay = n_pay;
        v.pay_sent = pay_sent;  v.n_pad = n_pad;  v.gap = gap;
        v.bad_cs = bad;  v.exp_err = err;  v.exp_acc = acc;
        return v;
    endfunction

    task automatic build(input vec_t v);
        int          ihl;
        logic [31:0] sum;
        logic [15:0] cs;
        ihl = int'(v.ver_ihl[3:0]);
        nh  = (ihl > 5) ? ihl * 4 : 20;
        for (int i = 0; i < 64; i++) hb[i] = 8'h00;
        hb[0] = v.ver_ihl;
        hb[2] = v.tot[15:8];   hb[3] = v.tot[7:0];
        hb[6] = v.frag[15:8];  hb[7] = v.frag[7:0];
        hb[8] = 8'h40;         hb[9] = v.proto;
        for (int i = 0; i < 4; i++) begin
            hb[12+i] = v.src[31-8*i -: 8];
            hb[16+i] = v.dst[31-8*i -: 8];
        end
        sum = 32'd0;
        for (int i = 0; i < nh; i += 2) sum = sum + {16'd0, hb[i], hb[i+1]};
        sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        cs = ~sum[15:0];
        if (v.bad_cs) cs = cs + 16'd1;
        hb[10] = cs[15:8];
        hb[11] = cs[7:0];
    endtask

    task automatic drive(input logic vld, input logic [7:0] b);
        @(negedge RX_CLK);
        rx_payload_ipv4 = vld;
        rx_payload      = b;
    endtask

    task automatic send(input vec_t v, input int vi);
        int         err0, hsent;
        logic [7:0] b;
        logic       lst;
        build(v);
        err0  = err_seen;
        hsent = (v.hdr_bytes == 0) ? nh : v.hdr_bytes;
        for (int i = 0; i < hsent; i++) drive(1'b1, hb[i]);
        if (hsent == nh) begin
            for (int k = 0; k < v.pay_sent; k++) begin
                b   = 8'(k + 16 * vi);
                lst = (k == v.n_pay - 1);
                if (v.exp_acc) exp_q.push_back({lst, b});
                drive(1'b1, b);
            end
            if (v.pay_sent == v.n_pay)
                for (int k = 0; k < v.n_pad; k++) drive(1'b1, 8'hA5);
        end
        for (int k = 0; k < v.gap; k++) drive(1'b0, 8'h00);
        @(posedge RX_CLK);
        #2;
        if (v.exp_acc) begin
            m_src   = v.src;
            m_proto = v.proto;
            m_len   = v.tot - 16'(4 * int'(v.ver_ihl[3:0]));
        end
        chk($sformatf("v%0d err_pulses", vi), 32'(err_seen - err0), {31'd0, v.exp_err});
        chk($sformatf("v%0d missing_bytes", vi), 32'(exp_q.size()), 32'd0);
        chk($sformatf("v%0d rx_ip_src", vi), rx_ip_src, m_src);
        chk($sformatf("v%0d rx_ip_proto", vi), {24'd0, rx_ip_proto}, {24'd0, m_proto});
        chk($sformatf("v%0d rx_ip_len", vi), {16'd0, rx_ip_len}, {16'd0, m_len});
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " valid"}, {31'd0, rx_ipv4_valid}, 32'd0);
        chk({tag, " last"},  {31'd0, rx_ipv4_last},  32'd0);
        chk({tag, " err"},   {31'd0, rx_ipv4_err},   32'd0);
        chk({tag, " data"},  {24'd0, rx_ipv4_data},  32'd0);
        chk({tag, " src"},   rx_ip_src,              32'd0);
        chk({tag, " proto"}, {24'd0, rx_ip_proto},   32'd0);
        chk({tag, " len"},   {16'd0, rx_ip_len},     32'd0);
    endtask

    initial begin
        int err0;
        //           ver   tot      frag     pr     src           dst           hb  np  ps  pad gap bad    err     acc
        vt[0]  = mk(8'h45, 16'h001E, 16'h4000, 8'h11, SRC,          LOC,          0,  10, 10, 0,  2,  0,     0,      1);
        vt[1]  = mk(8'h45, 16'h001E, 16'h4000, 8'h11, SRC,          LOC,          0,  10, 10, 0,  2,  1,     CS_ON,  !CS_ON);
        vt[2]  = mk(8'h45, 16'h001E, 16'h4000, 8'h11, SRC,          32'hC0A8010B, 0,  10, 10, 0,  1,  0,     0,      0);
        vt[3]  = mk(8'h45, 16'h001E, 16'h4000, 8'h11, SRC,          LOC,          0,  10, 10, 0,  2,  0,     0,      1);
        vt[4]  = mk(8'h46, 16'h0022, 16'h4000, 8'h11, SRC,          LOC,          0,  10, 10, 0,  2,  0,     0,      1);
        vt[5]  = mk(8'h45, 16'h001E, 16'h4000, 8'h11, SRC,          LOC,          0,  10, 10, 16, 2,  0,     0,      1);
        vt[6]  = mk(8'h45, 16'h001E, 16'h4000, 8'h11, SRC,          LOC,          0,  10, 5,  0,  2,  0,     1,      1);
        vt[7]  = mk(8'h65, 16'h001E, 16'h4000, 8'h11, SRC,          LOC,          0,  10, 10, 0,  2,  0,     1,      0);
        vt[8]  = mk(8'h45, 16'h001E, 16'h2000, 8'h11, SRC,          LOC,          0,  10, 10, 0,  2,  0,     1,      0);
        vt[9]  = mk(8'h45, 16'h001E, 16'h4001, 8'h11, SRC,          LOC,          0,  10, 10, 0,  2,  0,     1,      0);
        vt[10] = mk(8'h45, 16'h0010, 16'h4000, 8'h11, SRC,          LOC,          0,  0,  0,  0,  2,  0,     1,      0);
        vt[11] = mk(8'h44, 16'h001E, 16'h4000, 8'h11, SRC,          LOC,          0,  10, 10, 0,  2,  0,     1,      0);
        vt[12] = mk(8'h45, 16'h0014, 16'h4000, 8'h11, SRC,          LOC,          0,  0,  0,  4,  2,  0,     0,      0);
        vt[13] = mk(8'h45, 16'h001E, 16'h4000, 8'h11, SRC,          LOC,          10, 10, 10, 0,  2,  0,     1,      0);
        vt[14] = mk(8'h45, 16'h0018, 16'h0000, 8'h06, 32'h0A000001, LOC,          0,  4,  4,  0,  2,  0,     0,      1);
        vt[15] = mk(8'h47, 16'h001F, 16'h4000, 8'h11, SRC,          LOC,          0,  3,  3,  2,  2,  0,     0,      1);
        vt[16] = mk(8'h46, 16'h0022, 16'h4000, 8'h11, SRC,          LOC,          22, 10, 10, 0,  2,  0,     1,      0);

        rst             = 1'b1;
        ip_addr         = LOC;
        rx_payload_ipv4 = 1'b0;
        rx_payload      = 8'h00;
        repeat (3) @(posedge RX_CLK);
        #1;
        chk_all_zero("reset");
        @(negedge RX_CLK);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) send(vt[i], i);

        // Reset while payload byte 3 is on the input.
        build(vt[0]);
        err0 = err_seen;
        for (int i = 0; i < nh; i++) drive(1'b1, hb[i]);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({1'b0, 8'(k)});
            drive(1'b1, 8'(k));
        end
        @(negedge RX_CLK);
        rx_payload = 8'd3;
        rst        = 1'b1;
        @(posedge RX_CLK);
        #1;
        chk_all_zero("mid_reset");
        @(negedge RX_CLK);
        rst             = 1'b0;
        rx_payload_ipv4 = 1'b0;
        @(posedge RX_CLK);
        #2;
        chk("mid_reset err_pulses", 32'(err_seen - err0), 32'd0);
        chk("mid_reset missing_bytes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        m_src   = '0;
        m_proto = '0;
        m_len   = '0;
        send(vt[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_ipv4.md
# rx_ipv4

IPv4 receive stage directly downstream of the Ethernet receive block. It consumes the byte stream that block emits for frames whose EtherType is IPv4 (`rx_payload` qualified by `rx_payload_ipv4`). It parses and validates the IPv4 header, filters on the local IP address, and forwards the IPv4 payload to the transport layer. Ethernet padding past the IPv4 total length is stripped.

## Interface
Parameters:
- `OCT`, 8, byte width.
- `IP_VER`, 4'h4, required version field.

Ports:
- `RX_CLK`  in  1  receive clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ip_addr`  in  32  local IPv4 address; byte 0 of the address is bits [31:24].
- `rx_payload_ipv4`  in  1  input byte valid; high for the whole IPv4 datagram, including padding.
- `rx_payload`  in  8  input byte.
- `rx_ip_src`  out  32  source address of the current or last accepted datagram.
- `rx_ip_proto`  out  8  protocol field of the current or last accepted datagram.
- `rx_ip_len`  out  16  payload length, computed as total_length − IHL*4.
- `rx_ipv4_valid`  out  1  payload byte valid.
- `rx_ipv4_data`  out  8  payload byte.
- `rx_ipv4_last`  out  1  high with the final payload byte.
- `rx_ipv4_err`  out  1  one-cycle pulse when a datagram is rejected.

## Operation
- **States:** IDLE, HEADER, OPTIONS, PAYLOAD, DROP.
- **IDLE:**
  - When `rx_payload_ipv4` is high, the current byte is header byte 0. Capture it, set hdr_cnt=1, go to HEADER.
- **HEADER (bytes 1–19):**
  - Capture the fields: version/IHL (byte 0), total_length (bytes 2–3), flags/fragment offset (bytes 6–7), protocol (byte 9), src (bytes 12–15), dst (bytes 16–19).
  - After byte 19: if IHL>5, go to OPTIONS and skip (IHL−5)*4 bytes. Otherwise run the header checks immediately.
- **Header checks,** evaluated on the last header byte:
  - version==IP_VER; IHL≥5; total_length≥IHL*4.
  - MF==0 and fragment offset==0 (fragments are not supported).
  - Checksum good (see Configuration).
  - dst==ip_addr.
- **Outcome of the checks:**
  - Any failure other than the dst check → `rx_ipv4_err` pulse, go to DROP.
  - dst mismatch → silent drop, go to DROP.
  - Pass with payload length 0 → go to DROP; no payload bytes and no `last` are produced.
  - Pass otherwise → load `rx_ip_src`, `rx_ip_proto` and `rx_ip_len`, then go to PAYLOAD.
- **PAYLOAD:**
  - Each valid input byte is forwarded and pay_cnt (16-bit) is incremented.
  - On the byte where pay_cnt reaches rx_ip_len, assert `last` and go to DROP.
- **DROP:** consume bytes until `rx_payload_ipv4` is low, then go to IDLE. This absorbs Ethernet padding.
- **Truncation:** if `rx_payload_ipv4` falls in HEADER, OPTIONS or PAYLOAD before the datagram is complete:
  - pulse `rx_ipv4_err` and go to IDLE;
  - `last` is never asserted for that datagram.
- **Length width rule:** IHL*4 is computed in 6 bits and zero-extended to 16; the subtraction is 16-bit.

## Timing
- **Reset values:** every output is 0; the state is IDLE.
- **Reset mid-datagram:** the reset takes effect on the next edge. Outputs clear and the partial datagram is discarded with no `err`.
- **Payload latency:** 1 cycle. An input byte sampled at edge k appears on `rx_ipv4_data` with `rx_ipv4_valid`=1 after edge k.
- **Valid gaps:** `rx_ipv4_valid` is high only for cycles that follow a sampled payload byte.
- **`rx_ipv4_last`** is coincident with the final `rx_ipv4_valid`.
- **`rx_ipv4_err`** is asserted the cycle after the failing header byte, or after the cycle in which valid was sampled low.
- **Field stability:** `rx_ip_src`, `rx_ip_proto` and `rx_ip_len` update one cycle before the first payload valid, and hold until the next accepted datagram.
- **Back-to-back datagrams:** at least one cycle with `rx_payload_ipv4` low is required between datagrams. No backpressure; the block accepts one byte per cycle.

## Configuration
- **`RX_IPV4_CHECKSUM_EN` defined:**
  - A one's-complement sum of 16-bit header words, including options, is accumulated byte-pairwise with end-around carry.
  - The header passes only if the final folded sum == 16'hFFFF.
- **`RX_IPV4_CHECKSUM_EN` undefined:** the accumulator is absent and the checksum check always passes.

## Test plan
All scenarios use ip_addr=C0A8010A.
- **Good datagram:** header 45 00 00 1E 00 00 40 00 40 11 B7 73 C0 A8 01 01 C0 A8 01 0A, then 10 payload bytes 00..09 → 10 valid cycles carrying 00..09, with last on 09. Expect rx_ip_src=C0A80101, rx_ip_proto=11, rx_ip_len=000A, no err.
- **Bad checksum:** same header with checksum B774:
  - with `RX_IPV4_CHECKSUM_EN` defined → one err pulse and no valid;
  - with it undefined → forwarded as in the good case.
- **Wrong destination:** dst C0A8010B with its checksum corrected → no valid, no err; a good datagram after a 1-cycle gap is accepted.
- **Options:** IHL=6, total_length=0022, 4 option bytes, 10 payload bytes → the options are not forwarded and exactly 10 payload bytes appear, with rx_ip_len=000A.
- **Padding and truncation:**
  - Good datagram plus 16 pad bytes → last on byte 10 and no further valid.
  - Valid dropped after payload byte 5 → 5 valid bytes, no last, one err pulse.
- **Reset mid-payload:** assert rst during payload byte 3 → all outputs 0 on the next edge and no err. A following datagram is received normally.
